eda_regional_extrema: RTL

//   Self-sequencing regional-extremum engine, successor to the regional-max datapath. It holds an
//   MxN image, and on start computes the binary regional-max mask (or regional-min mask) under
//   4- or 8-connectivity with an internal FSM and plateau-flood stack. No external center_addr or
//   new_pixel sequencing. The mask is then read back by address; sits between pixel loader and host.

---
 rtl/eda_regional_extrema_if.sv | 26 ++
 rtl/eda_regional_extrema.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/eda_regional_extrema_if.sv
// Host-side bus of the regional-extremum engine: image load, run control and mask readback.
interface eda_regional_extrema_if #(
  parameter int ADDR_WIDTH  = 6,
  parameter int PIXEL_WIDTH = 8
);
  logic                   write_en;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [PIXEL_WIDTH-1:0] pixel_in;
  logic                   start;
  logic                   find_min;
  logic                   conn8;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic                   mask_out;
  logic                   busy;
  logic                   done;

  modport master (
    output write_en, wr_addr, pixel_in, start, find_min, conn8, rd_addr,
    input  mask_out, busy, done
  );

  modport slave (
    input  write_en, wr_addr, pixel_in, start, find_min, conn8, rd_addr,
    output mask_out, busy, done
  );
endinterface

// File: rtl/eda_regional_extrema.sv
// Regional max/min mask engine: scans every pixel, and when a neighbour beats it, floods the
// whole equal-valued plateau out of the mask using an explicit stack.
module eda_regional_extrema #(
  parameter int M           = 6,
  parameter int N           = 6,
  parameter int PIXEL_WIDTH = 8,
  parameter int ADDR_WIDTH  = $clog2(M*N)
) (
  input logic             clk,
  input logic             reset_n,
  eda_regional_extrema_if.slave bus
);

  localparam int CELLS    = M * N;
  localparam int SP_WIDTH = $clog2(CELLS + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CELLS - 1);
  localparam logic [ADDR_WIDTH:0]   CELLS_X   = (ADDR_WIDTH+1)'(CELLS);
  localparam logic [SP_WIDTH-1:0]   DEPTH     = SP_WIDTH'(CELLS);

  typedef enum logic [2:0] {IDLE, INIT, SCAN, POP, NB, DONE} state_t;
  state_t state, state_next;

  logic [PIXEL_WIDTH-1:0] image [CELLS];
  logic [ADDR_WIDTH-1:0]  stack [CELLS];
  logic [CELLS-1:0]       mask;
  logic [SP_WIDTH-1:0]    sp;
  logic [ADDR_WIDTH-1:0]  p, p_next, r, center, q, clr_addr, push_data;
  logic [2:0]             k, k_next, k_last;
  logic                   find_min_q, conn8_q, mask_out_q, busy, rd_ok;
  logic                   q_valid, q_beats, q_equal;
  logic                   set_all, latch_mode, clr_en, push, pop, advance;
  logic [PIXEL_WIDTH-1:0] pix_c, pix_q;
  int                     crow, ccol, drow, dcol, nrow, ncol;

  assign busy   = (state == INIT) || (state == SCAN) || (state == POP) || (state == NB);
  assign k_last = conn8_q ? 3'd7 : 3'd3;
  assign rd_ok  = {1'b0, bus.rd_addr} < CELLS_X;

  // Slot k of the current centre (p while scanning, r while flooding) in visiting order.
  always_comb begin
    center = (state == NB) ? r : p;
    crow   = int'(center) / N;
    ccol   = int'(center) % N;
    drow   = 0;
    dcol   = 0;
    case (k)
      3'd0:    drow = -1;
      3'd1:    dcol = -1;
      3'd2:    dcol = 1;
      3'd3:    drow = 1;
      3'd4:    begin drow = -1; dcol = -1; end
      3'd5:    begin drow = -1; dcol = 1;  end
      3'd6:    begin drow = 1;  dcol = -1; end
      default: begin drow = 1;  dcol = 1;  end
    endcase
    nrow    = crow + drow;
    ncol    = ccol + dcol;
    q_valid = (nrow >= 0) && (nrow < M) && (ncol >= 0) && (ncol < N);
    q       = q_valid ? ADDR_WIDTH'(nrow * N + ncol) : '0;
    pix_c   = image[center];
    pix_q   = image[q];
    q_beats = find_min_q ? (pix_q < pix_c) : (pix_q > pix_c);
    q_equal = (pix_q == pix_c);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    set_all    = 1'b0;
    latch_mode = 1'b0;
    clr_en     = 1'b0;
    clr_addr   = p;
    push       = 1'b0;
    push_data  = p;
    pop        = 1'b0;
    advance    = 1'b0;
    k_next     = k;
    p_next     = p;
    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (bus.start) begin
          latch_mode = 1'b1;
          state_next = INIT;
        end
      end
      INIT: begin
        set_all    = 1'b1;
        p_next     = '0;
        k_next     = '0;
        state_next = SCAN;
      end
      SCAN: begin
        if (!mask[p]) begin
          advance = 1'b1;
        end else if (q_valid && q_beats) begin
          clr_en     = 1'b1;
          push       = 1'b1;
          k_next     = '0;
          state_next = POP;
        end else if (k == k_last) begin
          k_next  = '0;
          advance = 1'b1;
        end else begin
          k_next = k + 3'd1;
        end
      end
      POP: begin
        pop        = 1'b1;
        k_next     = '0;
        state_next = NB;
      end
      NB: begin
        if (q_valid && mask[q] && q_equal) begin
          clr_en    = 1'b1;
          clr_addr  = q;
          push      = 1'b1;
          push_data = q;
        end
        if (k == k_last) begin
          k_next = '0;
          if ((sp != '0) || push) state_next = POP;
          else                    advance    = 1'b1;
        end else begin
          k_next = k + 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (advance) begin
      if (p == LAST_ADDR) begin
        state_next = DONE;
      end else begin
        p_next     = p + 1'b1;
        state_next = SCAN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask       <= '0;
      sp         <= '0;
      p          <= '0;
      k          <= '0;
      r          <= '0;
      find_min_q <= 1'b0;
      conn8_q    <= 1'b0;
      mask_out_q <= 1'b0;
    end else begin
      if (latch_mode) begin
        find_min_q <= bus.find_min;
        conn8_q    <= bus.conn8;
      end
      if (set_all)     mask           <= '1;
      else if (clr_en) mask[clr_addr] <= 1'b0;
      if (push)        sp <= sp + 1'b1;
      else if (pop)    sp <= sp - 1'b1;
      if (pop)         r  <= stack[ADDR_WIDTH'(sp - 1'b1)];
      p          <= p_next;
      k          <= k_next;
      mask_out_q <= rd_ok ? mask[bus.rd_addr] : 1'b0;
    end
  end

  // Image and stack contents are plain storage and need no reset.
  always_ff @(posedge clk) begin
    if (bus.write_en && !busy && ({1'b0, bus.wr_addr} < CELLS_X))
      image[bus.wr_addr] <= bus.pixel_in;
    if (push)
      stack[ADDR_WIDTH'(sp)] <= push_data;
  end

  assert property (@(posedge clk) disable iff (!reset_n) push |-> (sp < DEPTH));

  assign bus.busy     = busy;
  assign bus.done     = (state == DONE);
  assign bus.mask_out = busy ? 1'b0 : mask_out_q;

endmodule
